// File: rtl/ts_result_collector_if.sv
// Handshake bundle between a result/query source (master) and
// ts_result_collector (slave): record stream in, statistics query in,
// statistics response out.
interface ts_result_collector_if #(
    parameter int ID_W  = 3,
    parameter int TS_W  = 8,
    parameter int CNT_W = 16,
    parameter int SUM_W = TS_W + CNT_W
);
    logic             in_valid;
    logic             in_ready;
    logic [ID_W-1:0]  in_id;
    logic [TS_W-1:0]  in_start_ts;
    logic [TS_W-1:0]  in_end_ts;
    logic [TS_W-1:0]  in_delta;

    logic             qry_valid;
    logic             qry_ready;
    logic [ID_W-1:0]  qry_id;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [ID_W-1:0]  rsp_id;
    logic [CNT_W-1:0] rsp_count;
    logic [TS_W-1:0]  rsp_min;
    logic [TS_W-1:0]  rsp_max;
    logic [SUM_W-1:0] rsp_sum;

    modport master (
        output in_valid, in_id, in_start_ts, in_end_ts, in_delta,
        output qry_valid, qry_id, rsp_ready,
        input  in_ready, qry_ready,
        input  rsp_valid, rsp_id, rsp_count, rsp_min, rsp_max, rsp_sum
    );

    modport slave (
        input  in_valid, in_id, in_start_ts, in_end_ts, in_delta,
        input  qry_valid, qry_id, rsp_ready,
        output in_ready, qry_ready,
        output rsp_valid, rsp_id, rsp_count, rsp_min, rsp_max, rsp_sum
    );
endinterface

// File: rtl/ts_result_collector.sv
// ts_result_collector: sink for the event_timestamper result stream.
// Checks each record's delta against end-start (mod 2**TS_W), keeps per-ID
// count/min/max/sum of the recomputed delta, and serves them through a
// query/response handshake.
// Optional feature: define TS_COLLECT_CLEAR_ON_READ_EN to make an accepted
// query reset the queried entry (a same-cycle record lands on the cleared entry).
module ts_result_collector #(
    parameter int ID_W  = 3,
    parameter int TS_W  = 8,
    parameter int CNT_W = 16,
    parameter int SUM_W = TS_W + CNT_W
) (
    input  logic                 clk,
    input  logic                 rst,
    ts_result_collector_if.slave bus,
    output logic                 err_delta,
    output logic [ID_W-1:0]      err_id
);
    localparam int N_ID = 1 << ID_W;

    typedef struct packed {
        logic [CNT_W-1:0] count;
        logic [TS_W-1:0]  dmin;
        logic [TS_W-1:0]  dmax;
        logic [SUM_W-1:0] sum;
    } entry_t;

    localparam entry_t ENTRY_RESET = '{
        count: {CNT_W{1'b0}},
        dmin:  {TS_W{1'b1}},
        dmax:  {TS_W{1'b0}},
        sum:   {SUM_W{1'b0}}
    };

    entry_t           stats [N_ID];
    logic             live;
    logic             in_ready;
    logic             qry_ready;
    logic             rec_fire;
    logic             qry_fire;
    logic             clear_hit;
    logic [TS_W-1:0]  calc;
    logic [SUM_W:0]   sum_ext;
    entry_t           rec_base;
    entry_t           rec_next;
    entry_t           qry_entry;

    logic             rsp_valid_q;
    logic [ID_W-1:0]  rsp_id_q;
    logic [CNT_W-1:0] rsp_count_q;
    logic [TS_W-1:0]  rsp_min_q;
    logic [TS_W-1:0]  rsp_max_q;
    logic [SUM_W-1:0] rsp_sum_q;

    // live is a registered copy of !rst, so both readies rise one cycle after release.
    assign in_ready      = live & ~rst;
    assign qry_ready     = live & ~rst & (~rsp_valid_q | bus.rsp_ready);
    assign bus.in_ready  = in_ready;
    assign bus.qry_ready = qry_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_count = rsp_count_q;
    assign bus.rsp_min   = rsp_min_q;
    assign bus.rsp_max   = rsp_max_q;
    assign bus.rsp_sum   = rsp_sum_q;

    // Handshakes, recomputed delta and the read-modify-write value for the record's entry.
    always_comb begin
        // NOTE: every comb output gets a default first so no path can infer a latch.
        rec_fire  = bus.in_valid & in_ready;
        qry_fire  = bus.qry_valid & qry_ready;
        calc      = bus.in_end_ts - bus.in_start_ts;
`ifdef TS_COLLECT_CLEAR_ON_READ_EN
        clear_hit = qry_fire;
`else
        clear_hit = 1'b0;
`endif
        rec_base  = (clear_hit && (bus.qry_id == bus.in_id)) ? ENTRY_RESET : stats[bus.in_id];
        sum_ext   = {1'b0, rec_base.sum} + (SUM_W+1)'(calc);

        rec_next.count = (&rec_base.count) ? rec_base.count : rec_base.count + CNT_W'(1);
        rec_next.sum   = sum_ext[SUM_W] ? {SUM_W{1'b1}} : sum_ext[SUM_W-1:0];
        rec_next.dmin  = (calc < rec_base.dmin) ? calc : rec_base.dmin;
        rec_next.dmax  = (calc > rec_base.dmax) ? calc : rec_base.dmax;

        qry_entry = stats[bus.qry_id];
    end

    // Ready tracking: readies come up the cycle after reset is released.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every block sees pre-edge values.
        if (rst) live <= 1'b0;
        else     live <= 1'b1;
    end

    // Statistics table: optional clear-on-read, then the record update (later write wins on a shared ID).
    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the table is a small register file that must come out of reset
            // in a defined state, so every entry is reset explicitly.
            for (int i = 0; i < N_ID; i++) stats[i] <= ENTRY_RESET;
        end else begin
            if (clear_hit) stats[bus.qry_id] <= ENTRY_RESET;
            if (rec_fire)  stats[bus.in_id]  <= rec_next;
        end
    end

    // Response register: loads pre-record statistics on an accepted query, holds until consumed.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_count_q <= '0;
            rsp_min_q   <= '0;
            rsp_max_q   <= '0;
            rsp_sum_q   <= '0;
        end else if (qry_fire) begin
            rsp_valid_q <= 1'b1;
            rsp_id_q    <= bus.qry_id;
            rsp_count_q <= qry_entry.count;
            rsp_min_q   <= (qry_entry.count == '0) ? '0 : qry_entry.dmin;
            rsp_max_q   <= (qry_entry.count == '0) ? '0 : qry_entry.dmax;
            rsp_sum_q   <= (qry_entry.count == '0) ? '0 : qry_entry.sum;
        end else if (bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

    // Sticky delta error flag; the ID is captured only for the first mismatch.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_delta <= 1'b0;
            err_id    <= '0;
        end else if (rec_fire && (calc != bus.in_delta)) begin
            err_delta <= 1'b1;
            if (!err_delta) err_id <= bus.in_id;
        end
    end
endmodule

// File: tb/tb_ts_result_collector.sv
// Self-checking bench for ts_result_collector: directed cases with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural per-ID statistics model. A second instance with CNT_W=2
// exercises count and sum saturation.
module tb_ts_result_collector;
    localparam int ID_W  = 3;
    localparam int TS_W  = 8;
    localparam int CNT_W = 16;
    localparam int SUM_W = TS_W + CNT_W;
    localparam int N_ID  = 1 << ID_W;
    localparam longint TS_MOD  = longint'(1) << TS_W;
    localparam longint CNT_MAX = (longint'(1) << CNT_W) - 1;
    localparam longint SUM_MAX = (longint'(1) << SUM_W) - 1;
`ifdef TS_COLLECT_CLEAR_ON_READ_EN
    localparam bit CLR = 1'b1;
`else
    localparam bit CLR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ts_result_collector_if #(.ID_W(ID_W), .TS_W(TS_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) bus_if ();
    logic            err_delta;
    logic [ID_W-1:0] err_id;

    ts_result_collector #(.ID_W(ID_W), .TS_W(TS_W), .CNT_W(CNT_W), .SUM_W(SUM_W)) dut (
        .clk(clk), .rst(rst), .bus(bus_if), .err_delta(err_delta), .err_id(err_id)
    );

    ts_result_collector_if #(.ID_W(ID_W), .TS_W(TS_W), .CNT_W(2), .SUM_W(TS_W + 2)) sbus ();
    logic            s_err_delta;
    logic [ID_W-1:0] s_err_id;

    ts_result_collector #(.ID_W(ID_W), .TS_W(TS_W), .CNT_W(2), .SUM_W(TS_W + 2)) dut_sat (
        .clk(clk), .rst(rst), .bus(sbus), .err_delta(s_err_delta), .err_id(s_err_id)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    longint m_cnt [N_ID];
    longint m_min [N_ID];
    longint m_max [N_ID];
    longint m_sum [N_ID];
    bit     m_init = 1'b0;
    bit     m_live = 1'b0;
    bit     m_rv   = 1'b0;
    bit     m_err  = 1'b0;
    longint m_err_id, m_rid, m_rc, m_rmin, m_rmax, m_rsum;

    bit     e_in_rdy, e_q_rdy, q_fire, r_fire;
    int     qid, iid;
    longint calc;

    function automatic void m_clear(input int id);
        m_cnt[id] = 0;
        m_min[id] = TS_MOD - 1;
        m_max[id] = 0;
        m_sum[id] = 0;
    endfunction

    // Compare DUT against the model mid-cycle, then advance the model over the next edge.
    always @(negedge clk) begin
        e_in_rdy = m_live && !rst;
        e_q_rdy  = e_in_rdy && (!m_rv || bus_if.rsp_ready);
        if (m_init) begin
            check("in_ready",  64'(bus_if.in_ready),  64'(e_in_rdy));
            check("qry_ready", 64'(bus_if.qry_ready), 64'(e_q_rdy));
            check("rsp_valid", 64'(bus_if.rsp_valid), 64'(m_rv));
            check("err_delta", 64'(err_delta),        64'(m_err));
            check("err_id",    64'(err_id),           64'(m_err_id));
            if (m_rv) begin
                check("rsp_id",    64'(bus_if.rsp_id),    64'(m_rid));
                check("rsp_count", 64'(bus_if.rsp_count), 64'(m_rc));
                check("rsp_min",   64'(bus_if.rsp_min),   64'(m_rmin));
                check("rsp_max",   64'(bus_if.rsp_max),   64'(m_rmax));
                check("rsp_sum",   64'(bus_if.rsp_sum),   64'(m_rsum));
            end
        end
        if (rst) begin
            for (int i = 0; i < N_ID; i++) m_clear(i);
            m_init = 1'b1; m_live = 1'b0; m_rv = 1'b0; m_err = 1'b0;
            m_err_id = 0; m_rid = 0; m_rc = 0; m_rmin = 0; m_rmax = 0; m_rsum = 0;
        end else if (m_init) begin
            q_fire = bus_if.qry_valid && e_q_rdy;
            r_fire = bus_if.in_valid && e_in_rdy;
            qid = int'(bus_if.qry_id);
            iid = int'(bus_if.in_id);
            m_live = 1'b1;
            if (q_fire) begin
                m_rv   = 1'b1;
                m_rid  = qid;
                m_rc   = m_cnt[qid];
                m_rmin = (m_cnt[qid] == 0) ? 0 : m_min[qid];
                m_rmax = (m_cnt[qid] == 0) ? 0 : m_max[qid];
                m_rsum = m_sum[qid];
                if (CLR) m_clear(qid);
            end else if (bus_if.rsp_ready) begin
                m_rv = 1'b0;
            end
            if (r_fire) begin
                calc = ((longint'(bus_if.in_end_ts) - longint'(bus_if.in_start_ts)) % TS_MOD + TS_MOD) % TS_MOD;
                if (calc != longint'(bus_if.in_delta)) begin
                    if (!m_err) m_err_id = iid;
                    m_err = 1'b1;
                end
                m_cnt[iid] = (m_cnt[iid] + 1 > CNT_MAX) ? CNT_MAX : m_cnt[iid] + 1;
                m_sum[iid] = (m_sum[iid] + calc > SUM_MAX) ? SUM_MAX : m_sum[iid] + calc;
                if (calc < m_min[iid]) m_min[iid] = calc;
                if (calc > m_max[iid]) m_max[iid] = calc;
            end
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_rec(input int id, input int s, input int e, input int d);
        bus_if.in_valid    = 1'b1;
        bus_if.in_id       = ID_W'(id);
        bus_if.in_start_ts = TS_W'(s);
        bus_if.in_end_ts   = TS_W'(e);
        bus_if.in_delta    = TS_W'(d);
        cyc();
        bus_if.in_valid    = 1'b0;
    endtask

    task automatic do_query(input string tag, input int id, input longint c, input longint mn,
                            input longint mx, input longint sm);
        int waited = 0;
        bus_if.qry_valid = 1'b1;
        bus_if.qry_id    = ID_W'(id);
        #1;
        while (!bus_if.qry_ready && waited < 20) begin
            cyc();
            waited++;
        end
        check({tag, "_accept"}, 64'(bus_if.qry_ready), 64'(1));
        cyc();
        bus_if.qry_valid = 1'b0;
        check({tag, "_valid"}, 64'(bus_if.rsp_valid), 64'(1));
        check({tag, "_id"},    64'(bus_if.rsp_id),    64'(id));
        check({tag, "_count"}, 64'(bus_if.rsp_count), 64'(c));
        check({tag, "_min"},   64'(bus_if.rsp_min),   64'(mn));
        check({tag, "_max"},   64'(bus_if.rsp_max),   64'(mx));
        check({tag, "_sum"},   64'(bus_if.rsp_sum),   64'(sm));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        bus_if.in_valid = 1'b0; bus_if.in_id = '0; bus_if.in_start_ts = '0;
        bus_if.in_end_ts = '0; bus_if.in_delta = '0;
        bus_if.qry_valid = 1'b0; bus_if.qry_id = '0; bus_if.rsp_ready = 1'b1;
        sbus.in_valid = 1'b0; sbus.in_id = '0; sbus.in_start_ts = '0;
        sbus.in_end_ts = '0; sbus.in_delta = '0;
        sbus.qry_valid = 1'b0; sbus.qry_id = '0; sbus.rsp_ready = 1'b1;

        // Case 1: reset for 3 cycles, readies low throughout, rise one cycle after release.
        rst = 1'b1;
        repeat (3) begin
            cyc();
            check("rst_in_ready",  64'(bus_if.in_ready),  64'(0));
            check("rst_qry_ready", 64'(bus_if.qry_ready), 64'(0));
        end
        rst = 1'b0;
        #1;
        check("rel_in_ready_same_cycle", 64'(bus_if.in_ready), 64'(0));
        cyc();
        check("rel_in_ready",  64'(bus_if.in_ready),  64'(1));
        check("rel_qry_ready", 64'(bus_if.qry_ready), 64'(1));
        do_query("c1_id0", 0, 0, 0, 0, 0);

        // Saturation: CNT_W=2 instance, 5 records of delta 255 on id0.
        for (int i = 0; i < 5; i++) begin
            sbus.in_valid = 1'b1; sbus.in_id = '0;
            sbus.in_start_ts = 8'd0; sbus.in_end_ts = 8'd255; sbus.in_delta = 8'd255;
            cyc();
        end
        sbus.in_valid  = 1'b0;
        sbus.qry_valid = 1'b1; sbus.qry_id = '0;
        cyc();
        sbus.qry_valid = 1'b0;
        check("sat_valid", 64'(sbus.rsp_valid), 64'(1));
        check("sat_count", 64'(sbus.rsp_count), 64'(3));
        check("sat_sum",   64'(sbus.rsp_sum),   64'(1023));
        check("sat_min",   64'(sbus.rsp_min),   64'(255));
        check("sat_max",   64'(sbus.rsp_max),   64'(255));

        // Case 2: three records on id2.
        send_rec(2, 10, 15, 5);
        send_rec(2, 20, 32, 12);
        send_rec(2, 40, 43, 3);
        do_query("c2_id2", 2, 3, 3, 12, 20);
        check("c2_err_delta", 64'(err_delta), 64'(0));

        // Case 3: wrapping timestamps are legal; then a real mismatch on id1.
        send_rec(5, 250, 4, 10);
        check("c3_wrap_no_err", 64'(err_delta), 64'(0));
        do_query("c3_id5", 5, 1, 10, 10, 10);
        send_rec(1, 0, 9, 7);
        check("c3_err_delta", 64'(err_delta), 64'(1));
        check("c3_err_id",    64'(err_id),    64'(1));
        send_rec(4, 0, 9, 1);
        check("c3_err_id_kept", 64'(err_id), 64'(1));

        // Case 4: response held under backpressure, then retire + accept in one cycle.
        cyc();
        bus_if.rsp_ready = 1'b0;
        bus_if.qry_valid = 1'b1; bus_if.qry_id = 3'd2;
        #1;
        check("c4_first_accept", 64'(bus_if.qry_ready), 64'(1));
        cyc();
        bus_if.qry_id = 3'd4;
        repeat (4) begin
            check("c4_hold_valid", 64'(bus_if.rsp_valid), 64'(1));
            check("c4_hold_qry_ready", 64'(bus_if.qry_ready), 64'(0));
            check("c4_hold_id",    64'(bus_if.rsp_id),    64'(2));
            check("c4_hold_count", 64'(bus_if.rsp_count), CLR ? 64'(0) : 64'(3));
            check("c4_hold_sum",   64'(bus_if.rsp_sum),   CLR ? 64'(0) : 64'(20));
            check("c4_hold_max",   64'(bus_if.rsp_max),   CLR ? 64'(0) : 64'(12));
            cyc();
        end
        bus_if.rsp_ready = 1'b1;
        #1;
        check("c4_release_qry_ready", 64'(bus_if.qry_ready), 64'(1));
        cyc();
        bus_if.qry_valid = 1'b0;
        check("c4_next_valid", 64'(bus_if.rsp_valid), 64'(1));
        check("c4_next_id",    64'(bus_if.rsp_id),    64'(4));
        cyc();

        // Case 5: record and query on id3 in the same cycle -> pre-record stats.
        bus_if.in_valid = 1'b1; bus_if.in_id = 3'd3;
        bus_if.in_start_ts = 8'd0; bus_if.in_end_ts = 8'd8; bus_if.in_delta = 8'd8;
        bus_if.qry_valid = 1'b1; bus_if.qry_id = 3'd3;
        cyc();
        bus_if.in_valid = 1'b0; bus_if.qry_valid = 1'b0;
        check("c5_same_cycle_valid", 64'(bus_if.rsp_valid), 64'(1));
        check("c5_same_cycle_count", 64'(bus_if.rsp_count), 64'(0));
        do_query("c5_again", 3, 1, 8, 8, 8);

        // Case 6: repeated queries; destructive only with clear-on-read.
        send_rec(6, 10, 15, 5);
        send_rec(6, 20, 32, 12);
        send_rec(6, 40, 43, 3);
        do_query("c6_first", 6, 3, 3, 12, 20);
        if (CLR) do_query("c6_second", 6, 0, 0, 0, 0);
        else     do_query("c6_second", 6, 3, 3, 12, 20);

        // Randomized traffic with occasional mid-operation resets.
        for (int c = 0; c < 4000; c++) begin
            rst = ($urandom_range(0, 599) == 0);
            bus_if.in_valid    = ($urandom_range(0, 2) != 0);
            bus_if.in_id       = ($urandom_range(0, 1) == 0) ? ID_W'($urandom_range(0, 1))
                                                             : ID_W'($urandom_range(0, N_ID - 1));
            bus_if.in_start_ts = TS_W'($urandom_range(0, 255));
            bus_if.in_end_ts   = TS_W'($urandom_range(0, 255));
            bus_if.in_delta    = ($urandom_range(0, 19) == 0) ? TS_W'($urandom_range(0, 255))
                                                              : bus_if.in_end_ts - bus_if.in_start_ts;
            bus_if.qry_valid   = ($urandom_range(0, 2) != 0);
            bus_if.qry_id      = ($urandom_range(0, 1) == 0) ? bus_if.in_id
                                                             : ID_W'($urandom_range(0, N_ID - 1));
            bus_if.rsp_ready   = ($urandom_range(0, 3) != 0);
            cyc();
        end
        rst = 1'b0;
        bus_if.in_valid = 1'b0; bus_if.qry_valid = 1'b0; bus_if.rsp_ready = 1'b1;
        repeat (4) cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
